// File: rtl/icache_fill_pkg.sv
// rtl/icache_fill_pkg.sv - shared constants and state enum for the QSPI icache line fill
// Purpose : QSPI opcode and mode bytes, phase lengths and the fill FSM state type.
// Ports   : none (package).
package icache_fill_pkg;

  localparam logic [7:0] QSPI_CMD_QREAD = 8'hEB;
  localparam logic [7:0] MODE_XIP       = 8'hA0;
  localparam logic [7:0] MODE_NONE      = 8'hFF;

  localparam int CMD_NIBBLES  = 2;
  localparam int ADDR_NIBBLES = 6;
  localparam int MODE_NIBBLES = 2;
  // Two cycles after the last DATA sample: the low nibble of the last byte,
  // then its held high nibble.
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fill_swap.sv
// rtl/fill_swap.sv - nibble hold/reorder/strobe stage for the icache fill
// Purpose : flash returns each byte high nibble first; the cache wants low
//           nibble first. The high nibble is held, the low nibble is emitted
//           the cycle after it is sampled, and the held high nibble follows.
// Ports   : clk, reset (sync, active high)
//           sample_i  - qspi_in is a valid data nibble this cycle
//           nib_i     - nibble from flash
//           dread_o   - reordered nibble to the cache
//           wstrobe_o - dread_o valid
module fill_swap (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_i,
  input  logic [3:0] nib_i,
  output logic [3:0] dread_o,
  output logic       wstrobe_o
);

  logic [3:0] hold_q, hold_d;
  logic [3:0] dread_q, dread_d;
  logic       strobe_q, strobe_d;
  logic       phase_q, phase_d;   // 0: next sample is a high nibble
  logic       pend_q, pend_d;     // held high nibble still owed to the cache

  always_comb begin
    hold_d   = hold_q;
    dread_d  = dread_q;
    strobe_d = 1'b0;
    pend_d   = 1'b0;
    phase_d  = sample_i ? ~phase_q : 1'b0;

    if (sample_i && !phase_q) begin
      hold_d = nib_i;
    end

    // In a continuous burst a low-nibble sample never coincides with a
    // pending high nibble, so the two branches keep the strobe gap-free.
    if (sample_i && phase_q) begin
      dread_d  = nib_i;
      strobe_d = 1'b1;
      pend_d   = 1'b1;
    end else if (pend_q) begin
      dread_d  = hold_q;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q   <= '0;
      dread_q  <= '0;
      strobe_q <= 1'b0;
      phase_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      dread_q  <= dread_d;
      strobe_q <= strobe_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
    end
  end

  assign dread_o   = dread_q;
  assign wstrobe_o = strobe_q;

endmodule

// File: rtl/icache_fill.sv
// rtl/icache_fill.sv - QPI quad-read line fill engine for the instruction cache
// Purpose : on a miss, reads one cache line from QSPI flash (EB command,
//           24-bit address, mode byte, dummy cycles, data) and streams it to
//           the cache one nibble per cycle, low nibble of each byte first.
// Config  : ICACHE_FILL_XIP_EN - send mode A0 and skip the command phase on
//           later fills (continuous read); undefined: mode FF, command always.
// Ports   : clk, reset (sync, active high)
//           pull      - cache miss request       tag       - miss line address
//           dread     - fill nibble              wstrobe_d - fill nibble valid
//           busy      - fill in progress
//           qspi_cs_n - flash select (low)       qspi_out  - nibble to flash
//           qspi_oe   - per-lane output enable   qspi_in   - nibble from flash
module icache_fill
  import icache_fill_pkg::*;
#(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 22,
  parameter int DUMMY       = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]    tag,
  output logic [3:0]                           dread,
  output logic                                 wstrobe_d,
  output logic                                 busy,
  output logic                                 qspi_cs_n,
  output logic [3:0]                           qspi_out,
  output logic [3:0]                           qspi_oe,
  input  logic [3:0]                           qspi_in
);

  localparam int LW          = $clog2(LINE_LENGTH);
  localparam int TW          = PA - LW;
  localparam int DATA_CYCLES = 2 * LINE_LENGTH;
  localparam int MAXC        = max_int(max_int(DATA_CYCLES, DUMMY), ADDR_NIBBLES);
  localparam int CW          = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_NIBBLES - 1);
  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_NIBBLES - 1);
  localparam logic [CW-1:0] MODE_LAST  = CW'(MODE_NIBBLES - 1);
  localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

`ifdef ICACHE_FILL_XIP_EN
  localparam logic [7:0] MODE_BYTE = MODE_XIP;
  localparam logic       XIP_EN    = 1'b1;
`else
  localparam logic [7:0] MODE_BYTE = MODE_NONE;
  localparam logic       XIP_EN    = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic            xip_q, xip_d;

  logic [23:0]     addr_w;
  logic [3:0]      addr_nib;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    tag_d   = tag_q;
    xip_d   = xip_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pull) begin
          tag_d   = tag;
          state_d = xip_q ? ST_ADDR : ST_CMD;
        end
      end
      ST_CMD: begin
        if (cnt_q == CMD_LAST) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
        end
      end
      ST_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          state_d = ST_MODE;
          cnt_d   = '0;
        end
      end
      ST_MODE: begin
        if (cnt_q == MODE_LAST) begin
          state_d = ST_DUMMY;
          cnt_d   = '0;
          xip_d   = XIP_EN;
        end
      end
      ST_DUMMY: begin
        if (cnt_q == DUMMY_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      // One cycle with pull ignored: the miss that started this fill may
      // still be visible while the cache valid bit settles.
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      xip_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      xip_q   <= xip_d;
    end
  end

  // Byte address of the line, zero-extended to the 24-bit flash address.
  assign addr_w = 24'({tag_q, {LW{1'b0}}});

  always_comb begin
    addr_nib = 4'h0;
    unique case (cnt_q[2:0])
      3'd0:    addr_nib = addr_w[23:20];
      3'd1:    addr_nib = addr_w[19:16];
      3'd2:    addr_nib = addr_w[15:12];
      3'd3:    addr_nib = addr_w[11:8];
      3'd4:    addr_nib = addr_w[7:4];
      3'd5:    addr_nib = addr_w[3:0];
      default: addr_nib = 4'h0;
    endcase
  end

  always_comb begin
    qspi_out  = 4'h0;
    qspi_oe   = 4'h0;
    qspi_cs_n = 1'b1;
    unique case (state_q)
      ST_CMD: begin
        qspi_cs_n = 1'b0;
        qspi_oe   = 4'hF;
        qspi_out  = cnt_q[0] ? QSPI_CMD_QREAD[3:0] : QSPI_CMD_QREAD[7:4];
      end
      ST_ADDR: begin
        qspi_cs_n = 1'b0;
        qspi_oe   = 4'hF;
        qspi_out  = addr_nib;
      end
      ST_MODE: begin
        qspi_cs_n = 1'b0;
        qspi_oe   = 4'hF;
        qspi_out  = cnt_q[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
      end
      ST_DUMMY, ST_DATA: begin
        qspi_cs_n = 1'b0;
      end
      default: begin
        qspi_cs_n = 1'b1;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  fill_swap u_swap (
    .clk       (clk),
    .reset     (reset),
    .sample_i  (state_q == ST_DATA),
    .nib_i     (qspi_in),
    .dread_o   (dread),
    .wstrobe_o (wstrobe_d)
  );

endmodule

// File: tb/tb_icache_fill.sv
// tb/tb_icache_fill.sv - self-checking bench for icache_fill
module tb_icache_fill;

  localparam int LINE_LENGTH = 4;
  localparam int PA          = 22;
  localparam int DUMMY       = 4;
  localparam int TW          = PA - $clog2(LINE_LENGTH);
  localparam int NB          = 2 * LINE_LENGTH;

`ifdef ICACHE_FILL_XIP_EN
  localparam bit XIP = 1'b1;
`else
  localparam bit XIP = 1'b0;
`endif

  // Fill timeline, indexed from the first CMD cycle (XIP fills start at 2).
  localparam int E_DATA0 = 10 + DUMMY;        // first data cycle
  localparam int E_CSEND = E_DATA0 + NB;      // first cycle with cs_n high again
  localparam int E_STR0  = E_DATA0 + 2;       // first strobe
  localparam int E_DONE  = E_CSEND + 2;       // done cycle, last busy cycle

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pull = 1'b0;
  logic [TW-1:0] tag = '0;
  logic [3:0]    qspi_in = 4'h0;
  logic [3:0]    dread;
  logic          wstrobe_d;
  logic          busy;
  logic          qspi_cs_n;
  logic [3:0]    qspi_out;
  logic [3:0]    qspi_oe;

  always #5 clk = ~clk;

  icache_fill #(.LINE_LENGTH(LINE_LENGTH), .PA(PA), .DUMMY(DUMMY)) dut (
    .clk       (clk),
    .reset     (reset),
    .pull      (pull),
    .tag       (tag),
    .dread     (dread),
    .wstrobe_d (wstrobe_d),
    .busy      (busy),
    .qspi_cs_n (qspi_cs_n),
    .qspi_out  (qspi_out),
    .qspi_oe   (qspi_oe),
    .qspi_in   (qspi_in)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]    line [LINE_LENGTH];   // bytes the flash holds for the next fill
  logic [7:0]    m_line [LINE_LENGTH];
  logic [TW-1:0] m_tag = '0;
  bit            m_busy = 1'b0;
  bit            m_xip = 1'b0;
  int            m_c = 0;
  int            m_o = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_xip  = 1'b0;
    end else if (!m_busy) begin
      if (pull) begin
        m_busy = 1'b1;
        m_c    = 0;
        m_o    = m_xip ? 2 : 0;
        m_tag  = tag;
        m_line = line;
      end
    end else begin
      m_c++;
      if (m_c + m_o > E_DONE) begin
        m_busy = 1'b0;
        if (XIP) m_xip = 1'b1;
      end
    end
  end

  function automatic logic [3:0] exp_out(input int e);
    int a;
    a = int'(m_tag) * LINE_LENGTH;
    if (e == 0) return 4'hE;
    if (e == 1) return 4'hB;
    if (e < 8)  return 4'((a >> (4 * (7 - e))) & 15);
    if (e < 10) return XIP ? ((e == 8) ? 4'hA : 4'h0) : 4'hF;
    return 4'h0;
  endfunction

  // ---------------- statistics for literal checks ----------------
  int         cs_low_cnt = 0;
  int         cs_falls = 0;
  int         run = 0;
  int         max_run = 0;
  bit         prev_cs = 1'b1;
  logic [3:0] out_q[$];
  logic [3:0] str_q[$];

  always @(negedge clk) begin
    int e, k, j;
    if (started) begin
      e = m_c + m_o;
      check("busy", busy, m_busy);
      if (!m_busy) begin
        check("cs_n_idle", qspi_cs_n, 1'b1);
        check("oe_idle", qspi_oe, 4'h0);
        check("out_idle", qspi_out, 4'h0);
        check("strobe_idle", wstrobe_d, 1'b0);
        qspi_in = 4'h0;
      end else begin
        check("cs_n", qspi_cs_n, (e < E_CSEND) ? 1'b0 : 1'b1);
        check("oe", qspi_oe, (e < 10) ? 4'hF : 4'h0);
        check("out", qspi_out, exp_out(e));
        check("strobe", wstrobe_d, (e >= E_STR0 && e < E_STR0 + NB) ? 1'b1 : 1'b0);
        if (e >= E_STR0 && e < E_STR0 + NB) begin
          j = e - E_STR0;
          check("dread", dread, (j % 2 == 0) ? m_line[j/2][3:0] : m_line[j/2][7:4]);
        end
        if (e >= E_DATA0 && e < E_CSEND) begin
          k = e - E_DATA0;
          qspi_in = (k % 2 == 0) ? m_line[k/2][7:4] : m_line[k/2][3:0];
        end else begin
          qspi_in = 4'h0;
        end
      end
      if (!qspi_cs_n) cs_low_cnt++;
      if (prev_cs && !qspi_cs_n) cs_falls++;
      prev_cs = qspi_cs_n;
      if (qspi_oe == 4'hF) out_q.push_back(qspi_out);
      if (wstrobe_d) begin
        str_q.push_back(dread);
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    cs_low_cnt = 0;
    cs_falls   = 0;
    run        = 0;
    max_run    = 0;
    out_q.delete();
    str_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic start_fill(input logic [TW-1:0] t);
    tag  = t;
    pull = 1'b1;
    tick();
    pull = 1'b0;
  endtask

  task automatic check_nibs(input string name, input logic [3:0] got[$], input logic [3:0] exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(name, got[i], exp[i]);
  endtask

  task automatic set_line(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    line[0] = b0;
    line[1] = b1;
    line[2] = b2;
    line[3] = b3;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [3:0] exp_q[$];
    int n;

    set_line(8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    started = 1'b1;
    tick();
    check("rst_cs_n", qspi_cs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_oe", qspi_oe, 4'h0);
    check("rst_out", qspi_out, 4'h0);
    check("rst_strobe", wstrobe_d, 1'b0);
    check("rst_dread", dread, 4'h0);
    reset = 1'b0;
    tick();

    // Fill 1: tag 0x12345, address 0x048D14, bytes 3C A5 0F 96.
    clear_stats();
    set_line(8'h3C, 8'hA5, 8'h0F, 8'h96);
    start_fill(20'h12345);
    wait_idle(80);
    tick();
    check("f1_cs_low", cs_low_cnt, 22);
    exp_q = '{4'hE, 4'hB, 4'h0, 4'h4, 4'h8, 4'hD, 4'h1, 4'h4,
              XIP ? 4'hA : 4'hF, XIP ? 4'h0 : 4'hF};
    check_nibs("f1_out", out_q, exp_q);
    exp_q = '{4'hC, 4'h3, 4'h5, 4'hA, 4'hF, 4'h0, 4'h6, 4'h9};
    check_nibs("f1_dread", str_q, exp_q);
    check("f1_run", max_run, 8);

    // Fill 2, straight after: tag 0x00ABC, address 0x002AF0.
    clear_stats();
    set_line(8'h12, 8'h34, 8'h56, 8'h78);
    start_fill(20'h00ABC);
    wait_idle(80);
    tick();
    check("f2_cs_low", cs_low_cnt, XIP ? 20 : 22);
    exp_q = {};
    if (!XIP) begin
      exp_q.push_back(4'hE);
      exp_q.push_back(4'hB);
    end
    exp_q = {exp_q, 4'h0, 4'h0, 4'h2, 4'hA, 4'hF, 4'h0};
    exp_q = {exp_q, XIP ? 4'hA : 4'hF, XIP ? 4'h0 : 4'hF};
    check_nibs("f2_out", out_q, exp_q);
    exp_q = '{4'h2, 4'h1, 4'h4, 4'h3, 4'h6, 4'h5, 4'h8, 4'h7};
    check_nibs("f2_dread", str_q, exp_q);

    // Fill 3: pull dropped during ADDR, top line address 0x3FFFFC.
    clear_stats();
    set_line(8'h00, 8'hFF, 8'h5A, 8'hC3);
    tag  = 20'hFFFFF;
    pull = 1'b1;
    tick();
    tick();
    tick();
    pull = 1'b0;
    wait_idle(80);
    tick();
    exp_q = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hA, 4'h5, 4'h3, 4'hC};
    check_nibs("f3_dread", str_q, exp_q);
    check("f3_run", max_run, 8);
    check("f3_busy", busy, 1'b0);

    // Fill 4: pull held through DONE; one IDLE cycle, then a second burst.
    clear_stats();
    set_line(8'h01, 8'h23, 8'h45, 8'h67);
    tag  = 20'h00001;
    pull = 1'b1;
    tick();
    n = 0;
    while (busy !== 1'b0 && n < 80) begin
      tick();
      n++;
    end
    check("f4_first_end", busy, 1'b0);
    tick();
    check("f4_restart", busy, 1'b1);
    pull = 1'b0;
    wait_idle(80);
    tick();
    check("f4_cs_falls", cs_falls, 2);
    check("f4_strobes", str_q.size(), 16);
    check("f4_run", max_run, 8);

    // Fill 5: reset during DATA nibble 3, then a fresh fill runs CMD.
    clear_stats();
    set_line(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    start_fill(20'h0F0F0);
    n = 0;
    while (!(m_busy && (m_c + m_o) == E_DATA0 + 3) && n < 60) begin
      tick();
      n++;
    end
    check("f5_reach_data3", (m_c + m_o), E_DATA0 + 3);
    reset = 1'b1;
    tick();
    check("f5_rst_cs_n", qspi_cs_n, 1'b1);
    check("f5_rst_strobe", wstrobe_d, 1'b0);
    check("f5_rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    clear_stats();
    set_line(8'h96, 8'h0F, 8'hA5, 8'h3C);
    start_fill(20'h54321);
    check("f5_cmd_out", qspi_out, 4'hE);
    check("f5_cmd_oe", qspi_oe, 4'hF);
    wait_idle(80);
    tick();
    check("f5_cs_low", cs_low_cnt, 22);
    exp_q = '{4'h6, 4'h9, 4'hF, 4'h0, 4'h5, 4'hA, 4'hC, 4'h3};
    check_nibs("f5_dread", str_q, exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
